// File: rtl/sc_regdeserializer.sv
// Serial-to-parallel word assembler with start/clear/ack handshake and selectable bit order.
// Optional even-parity check enabled by defining SC_REGDESERIALIZER_PARITY_EN.
module sc_regdeserializer #(
  parameter int unsigned RegDESERIALIZER_DATAWIDTH = 8
) (
  input  logic                                 SC_RegDESERIALIZER_CLOCK_50,
  input  logic                                 SC_RegDESERIALIZER_RESET_InHigh,
  input  logic                                 SC_RegDESERIALIZER_clear_InLow,
  input  logic                                 SC_RegDESERIALIZER_start_InLow,
  input  logic                                 SC_RegDESERIALIZER_bitvalid_In,
  input  logic                                 SC_RegDESERIALIZER_bit_In,
  input  logic                                 SC_RegDESERIALIZER_shiftselection_In,
  input  logic                                 SC_RegDESERIALIZER_ack_InLow,
  output logic [RegDESERIALIZER_DATAWIDTH-1:0] SC_RegDESERIALIZER_data_OutBUS,
  output logic                                 SC_RegDESERIALIZER_valid_Out,
  output logic                                 SC_RegDESERIALIZER_busy_Out,
  output logic                                 SC_RegDESERIALIZER_parityerror_Out
);

  localparam int unsigned DW = RegDESERIALIZER_DATAWIDTH;
  localparam int unsigned CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

`ifdef SC_REGDESERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    HOLD   = 2'd2,
    PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   shifted;
`ifdef SC_REGDESERIALIZER_PARITY_EN
  logic            perr_q, perr_d;
`endif

  // Incoming bit lands in LSB (MSB-first) or MSB (LSB-first), chosen per bit.
  always_comb begin
    shifted = shreg_q;
    if (SC_RegDESERIALIZER_shiftselection_In) begin
      shifted = {SC_RegDESERIALIZER_bit_In, shreg_q[DW-1:1]};
    end else begin
      shifted = {shreg_q[DW-2:0], SC_RegDESERIALIZER_bit_In};
    end
  end

  // Next-state and next-output logic; clear overrides every state.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef SC_REGDESERIALIZER_PARITY_EN
    perr_d  = perr_q;
`endif

    if (!SC_RegDESERIALIZER_clear_InLow) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
`ifdef SC_REGDESERIALIZER_PARITY_EN
      perr_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!SC_RegDESERIALIZER_start_InLow) begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (SC_RegDESERIALIZER_bitvalid_In) begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
`ifdef SC_REGDESERIALIZER_PARITY_EN
              state_d = PARITY;
`else
              data_d  = shifted;
              valid_d = 1'b1;
              state_d = HOLD;
`endif
            end
          end
        end
`ifdef SC_REGDESERIALIZER_PARITY_EN
        PARITY: begin
          // Even parity: word bits plus parity bit must XOR to zero.
          if (SC_RegDESERIALIZER_bitvalid_In) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            perr_d  = (^shreg_q) ^ SC_RegDESERIALIZER_bit_In;
            state_d = HOLD;
          end
        end
`endif
        HOLD: begin
          if (!SC_RegDESERIALIZER_ack_InLow) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

`ifdef SC_REGDESERIALIZER_PARITY_EN
    busy_d = (state_d == SHIFT) || (state_d == PARITY);
`else
    busy_d = (state_d == SHIFT);
`endif
  end

  always_ff @(posedge SC_RegDESERIALIZER_CLOCK_50 or posedge SC_RegDESERIALIZER_RESET_InHigh) begin
    if (SC_RegDESERIALIZER_RESET_InHigh) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SC_REGDESERIALIZER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef SC_REGDESERIALIZER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign SC_RegDESERIALIZER_data_OutBUS = data_q;
  assign SC_RegDESERIALIZER_valid_Out   = valid_q;
  assign SC_RegDESERIALIZER_busy_Out    = busy_q;
`ifdef SC_REGDESERIALIZER_PARITY_EN
  assign SC_RegDESERIALIZER_parityerror_Out = perr_q;
`else
  assign SC_RegDESERIALIZER_parityerror_Out = 1'b0;
`endif

endmodule

// File: tb/tb_sc_regdeserializer.sv
// Self-checking bench for sc_regdeserializer: directed frames plus randomized frames
// against an arithmetic word model.
module tb_sc_regdeserializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         start;
  logic         bv;
  logic         b;
  logic         sel;
  logic         ack;
  logic [W-1:0] data;
  logic         valid;
  logic         busy;
  logic         perr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sc_regdeserializer #(.RegDESERIALIZER_DATAWIDTH(W)) dut (
    .SC_RegDESERIALIZER_CLOCK_50          (clk),
    .SC_RegDESERIALIZER_RESET_InHigh      (rst),
    .SC_RegDESERIALIZER_clear_InLow       (clr),
    .SC_RegDESERIALIZER_start_InLow       (start),
    .SC_RegDESERIALIZER_bitvalid_In       (bv),
    .SC_RegDESERIALIZER_bit_In            (b),
    .SC_RegDESERIALIZER_shiftselection_In (sel),
    .SC_RegDESERIALIZER_ack_InLow         (ack),
    .SC_RegDESERIALIZER_data_OutBUS       (data),
    .SC_RegDESERIALIZER_valid_Out         (valid),
    .SC_RegDESERIALIZER_busy_Out          (busy),
    .SC_RegDESERIALIZER_parityerror_Out   (perr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word model: MSB-first multiplies by two and adds the bit; LSB-first halves and adds bit*128.
  function automatic logic [W-1:0] model_push(input logic [W-1:0] w, input logic bit_v, input logic lsb_first);
    int unsigned v;
    if (lsb_first) v = (int'(w) / 2) + (bit_v ? 128 : 0);
    else           v = ((int'(w) * 2) % 256) + (bit_v ? 1 : 0);
    return W'(v);
  endfunction

  task automatic check_all(input string tag, input logic [W-1:0] d, input logic v,
                           input logic bz, input logic pe);
    check({tag, "_data"},  32'(data),  32'(d));
    check({tag, "_valid"}, 32'(valid), 32'(v));
    check({tag, "_busy"},  32'(busy),  32'(bz));
    check({tag, "_perr"},  32'(perr),  32'(pe));
  endtask

  // Full frame: bit i of the stream is seq[W-1-i] with order sels[W-1-i]; spurious start/ack
  // pulses and bitvalid gaps are injected where they must be ignored.
  task automatic do_frame(input string tag, input logic [W-1:0] seq, input logic [W-1:0] sels,
                          input int max_gap, input logic pbit, input int ack_dly);
    logic [W-1:0] exp_w;
    logic         exp_pe;
    exp_w = '0;
    exp_pe = 1'b0;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    check({tag, "_busy_at_start"}, 32'(busy), 32'd1);
    check({tag, "_valid_at_start"}, 32'(valid), 32'd0);
    for (int i = 0; i < int'(W); i++) begin
      int n_gap;
      n_gap = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 1));
      for (int g = 0; g < n_gap; g++) begin
        bv = 1'b0; b = 1'($urandom); sel = 1'($urandom);
        start = 1'($urandom); ack = 1'($urandom);
        @(negedge clk);
      end
      bv = 1'b1; b = seq[W-1-i]; sel = sels[W-1-i];
      start = 1'($urandom); ack = 1'($urandom);
      exp_w = model_push(exp_w, b, sel);
      @(negedge clk);
    end
    bv = 1'b0; start = 1'b1; ack = 1'b1; b = pbit;
`ifdef SC_REGDESERIALIZER_PARITY_EN
    check({tag, "_valid_before_parity"}, 32'(valid), 32'd0);
    check({tag, "_busy_before_parity"}, 32'(busy), 32'd1);
    bv = 1'b1;
    @(negedge clk);
    bv = 1'b0;
    exp_pe = (^exp_w) ^ pbit;
`endif
    check_all({tag, "_done"}, exp_w, 1'b1, 1'b0, exp_pe);
    for (int k = 0; k < ack_dly; k++) begin
      start = 1'($urandom);
      @(negedge clk);
      check({tag, "_valid_hold"}, 32'(valid), 32'd1);
    end
    ack = 1'b0;
    @(negedge clk);
    ack = 1'b1; start = 1'b1;
    check_all({tag, "_acked"}, exp_w, 1'b0, 1'b0, exp_pe);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b1; start = 1'b1; bv = 1'b0; b = 1'b0; sel = 1'b0; ack = 1'b1;
    #1;
    check_all("reset", '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("post_reset", '0, 1'b0, 1'b0, 1'b0);

    // Bits ignored while idle
    bv = 1'b1; b = 1'b1; ack = 1'b0;
    repeat (3) @(negedge clk);
    bv = 1'b0; ack = 1'b1;
    check_all("idle_ignore", '0, 1'b0, 1'b0, 1'b0);

    do_frame("msb_b2", 8'hB2, 8'h00, 0, 1'b0, 0);
    do_frame("lsb_4d", 8'hB2, 8'hFF, 0, 1'b0, 2);
    check("lsb_4d_const", 32'(data), 32'h4D);
    do_frame("gaps_b2", 8'hB2, 8'h00, 2, 1'b0, 1);
    do_frame("mixed_sel", 8'h5A, 8'h0F, 1, 1'b1, 0);

    // Abort after four bits
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bv = 1'b1; b = 1'b1; sel = 1'b0;
      @(negedge clk);
    end
    bv = 1'b0; clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    check_all("clear", '0, 1'b0, 1'b0, 1'b0);
    bv = 1'b1; b = 1'b1;
    repeat (2) @(negedge clk);
    bv = 1'b0;
    check_all("clear_idle", '0, 1'b0, 1'b0, 1'b0);
    do_frame("after_clear_ff", 8'hFF, 8'h00, 0, 1'b0, 0);

    // Asynchronous reset between edges during a frame
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bv = 1'b1; b = 1'b1; sel = 1'b0;
      @(negedge clk);
    end
    bv = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all("async_reset", '0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all("after_reset_idle", '0, 1'b0, 1'b0, 1'b0);
    do_frame("after_reset_01", 8'h01, 8'h00, 0, 1'b0, 0);

`ifdef SC_REGDESERIALIZER_PARITY_EN
    do_frame("par_ok", 8'hB2, 8'h00, 0, 1'b0, 0);
    check("par_ok_flag", 32'(perr), 32'd0);
    do_frame("par_bad", 8'hB2, 8'h00, 0, 1'b1, 0);
    check("par_bad_flag", 32'(perr), 32'd1);
`endif

    for (int f = 0; f < 16; f++) begin
      do_frame("rand", W'($urandom), W'($urandom), int'($urandom_range(2, 0)),
               1'($urandom), int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
